// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter
//   Shares one non-pipelined multi-cycle functional unit between NUM_REQ
//   issue queues. A round-robin arbiter picks one ready queue whenever the
//   unit can take a new op, latches that queue's function code and register
//   tags, counts the unit through FU_LATENCY cycles and then holds the result
//   tag until the common data bus acknowledges it.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   flush            synchronous squash of the in-flight op
//   req_ready        issue_ready per queue
//   req_func         function code per queue, queue i at [i*FUNC_WIDTH +: FUNC_WIDTH]
//   req_inp1/2       source tags per queue, packed the same way
//   req_dst          destination tag per queue
//   grant            one-hot issue strobe to the queues (combinational)
//   fu_start         one-cycle pulse: latched operands valid at the unit
//   fu_func/inp1/2   latched function code and source tags
//   result_valid     result ready for the CDB
//   result_dst       destination tag of the result
//   result_src       index of the queue that issued the op
//   cdb_ack          CDB accepted the result this cycle
//   busy             unit is executing or holding a result
module fu_issue_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int FUNC_WIDTH     = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FU_LATENCY     = 3,
  localparam int SRC_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*FUNC_WIDTH-1:0]     req_func,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_inp1,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_inp2,
  input  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_dst,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              fu_start,
  output logic [FUNC_WIDTH-1:0]             fu_func,
  output logic [REG_ADDR_WIDTH-1:0]         fu_inp1,
  output logic [REG_ADDR_WIDTH-1:0]         fu_inp2,
  output logic                              result_valid,
  output logic [REG_ADDR_WIDTH-1:0]         result_dst,
  output logic [SRC_W-1:0]                  result_src,
  input  logic                              cdb_ack,
  output logic                              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(FU_LATENCY - 1);

  state_e                    state_q;
  logic [SRC_W-1:0]          rr_ptr_q;
  logic [SRC_W-1:0]          rr_ptr_d;
  logic [3:0]                cnt_q;
  logic                      fu_start_q;
  logic [FUNC_WIDTH-1:0]     fu_func_q;
  logic [REG_ADDR_WIDTH-1:0] fu_inp1_q;
  logic [REG_ADDR_WIDTH-1:0] fu_inp2_q;
  logic                      result_valid_q;
  logic [REG_ADDR_WIDTH-1:0] result_dst_q;
  logic [SRC_W-1:0]          result_src_q;

  logic                      can_accept;
  logic                      do_grant;
  logic                      win_found;
  logic [SRC_W-1:0]          win_idx;
  logic [FUNC_WIDTH-1:0]     win_func;
  logic [REG_ADDR_WIDTH-1:0] win_inp1;
  logic [REG_ADDR_WIDTH-1:0] win_inp2;
  logic [REG_ADDR_WIDTH-1:0] win_dst;

  // A new op may start from IDLE, or from DONE in the same cycle the CDB
  // takes the previous result (back-to-back, no bubble).
  assign can_accept = !reset && !flush &&
                      ((state_q == IDLE) || ((state_q == DONE) && cdb_ack));

  // Round-robin scan starting at rr_ptr_q; pos wraps with one subtraction
  // because rr_ptr_q is always below NUM_REQ.
  always_comb begin
    int unsigned pos;
    pos       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_func  = '0;
    win_inp1  = '0;
    win_inp2  = '0;
    win_dst   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= unsigned'(NUM_REQ)) pos = pos - unsigned'(NUM_REQ);
      if (!win_found && req_ready[pos]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(pos);
        win_func  = req_func[pos*FUNC_WIDTH +: FUNC_WIDTH];
        win_inp1  = req_inp1[pos*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        win_inp2  = req_inp2[pos*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        win_dst   = req_dst[pos*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      end
    end
  end

  assign do_grant = can_accept && win_found;
  assign grant    = do_grant ? (NUM_REQ'(1) << win_idx) : '0;
  assign rr_ptr_d = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      fu_start_q     <= 1'b0;
      fu_func_q      <= '0;
      fu_inp1_q      <= '0;
      fu_inp2_q      <= '0;
      result_valid_q <= 1'b0;
      result_dst_q   <= '0;
      result_src_q   <= '0;
    end else begin
      fu_start_q <= 1'b0;
      if (flush) begin
        state_q        <= IDLE;
        result_valid_q <= 1'b0;
      end else if (do_grant) begin
        fu_start_q   <= 1'b1;
        fu_func_q    <= win_func;
        fu_inp1_q    <= win_inp1;
        fu_inp2_q    <= win_inp2;
        result_dst_q <= win_dst;
        result_src_q <= win_idx;
        rr_ptr_q     <= rr_ptr_d;
        cnt_q        <= CNT_INIT;
        if (FU_LATENCY == 1) begin
          state_q        <= DONE;
          result_valid_q <= 1'b1;
        end else begin
          state_q        <= EXEC;
          result_valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          EXEC: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == 4'd1) begin
              state_q        <= DONE;
              result_valid_q <= 1'b1;
            end
          end
          DONE: begin
            if (cdb_ack) begin
              state_q        <= IDLE;
              result_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign fu_start     = fu_start_q;
  assign fu_func      = fu_func_q;
  assign fu_inp1      = fu_inp1_q;
  assign fu_inp2      = fu_inp2_q;
  assign result_valid = result_valid_q;
  assign result_dst   = result_dst_q;
  assign result_src   = result_src_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Testbench for fu_issue_arbiter: a latency-3 instance driven through
// directed scenarios with a cycle-level reference model and result
// scoreboard, plus a latency-1 instance for back-to-back streaming.
module tb_fu_issue_arbiter;

  localparam int LAT = 3;
  localparam logic [3:0] ALU_ADD = 4'h1;

  typedef struct {
    logic [3:0] func;
    logic [4:0] i1;
    logic [4:0] i2;
    logic [4:0] dst;
    logic       src;
  } op_t;

  logic       clk = 1'b0;
  logic       reset, flush, ack;
  logic [1:0] ready;
  logic [7:0] func;
  logic [9:0] inp1, inp2, dst;
  logic [1:0] grant;
  logic       fu_start, result_valid, busy;
  logic [3:0] fu_func;
  logic [4:0] fu_inp1, fu_inp2, result_dst;
  logic [0:0] result_src;

  logic       flush1, ack1;
  logic [1:0] ready1;
  logic [7:0] func1;
  logic [9:0] inp1_1, inp2_1, dst1;
  logic [1:0] grant1;
  logic       fu_start1, result_valid1, busy1;
  logic [3:0] fu_func1;
  logic [4:0] fu_inp1_1, fu_inp2_1, result_dst1;
  logic [0:0] result_src1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fu_issue_arbiter #(.NUM_REQ(2), .FUNC_WIDTH(4), .REG_ADDR_WIDTH(5), .FU_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .req_ready(ready),
    .req_func(func), .req_inp1(inp1), .req_inp2(inp2), .req_dst(dst),
    .grant(grant), .fu_start(fu_start), .fu_func(fu_func),
    .fu_inp1(fu_inp1), .fu_inp2(fu_inp2), .result_valid(result_valid),
    .result_dst(result_dst), .result_src(result_src), .cdb_ack(ack), .busy(busy)
  );

  fu_issue_arbiter #(.NUM_REQ(2), .FUNC_WIDTH(4), .REG_ADDR_WIDTH(5), .FU_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .req_ready(ready1),
    .req_func(func1), .req_inp1(inp1_1), .req_inp2(inp2_1), .req_dst(dst1),
    .grant(grant1), .fu_start(fu_start1), .fu_func(fu_func1),
    .fu_inp1(fu_inp1_1), .fu_inp2(fu_inp2_1), .result_valid(result_valid1),
    .result_dst(result_dst1), .result_src(result_src1), .cdb_ack(ack1), .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops();
    func = 8'($urandom);
    inp1 = 10'($urandom);
    inp2 = 10'($urandom);
    dst  = 10'($urandom);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k;
    k = 0;
    while (result_valid !== 1'b1 && k < max) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(result_valid), 32'd1);
  endtask

  // Reference model of the latency-3 instance. Sampled at the falling edge;
  // inputs are stable from there to the next rising edge, so the model's
  // update here describes the state after that rising edge.
  bit   m_busy = 1'b0, m_valid = 1'b0, m_start = 1'b0, m_zero = 1'b1;
  int   m_rr = 0, m_rem = 0;
  op_t  sb[$];

  always @(negedge clk) begin
    logic [1:0] eg;
    bit         acc;
    int         w;
    op_t        op;
    acc = !reset && !flush && (!m_busy || (m_valid && ack));
    w   = -1;
    if (acc) begin
      for (int k = 0; k < 2; k++) begin
        int idx;
        idx = (m_rr + k) % 2;
        if (w < 0 && ready[idx]) w = idx;
      end
    end
    eg = (w >= 0) ? (2'b01 << w) : 2'b00;
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("result_valid", 32'(result_valid), 32'(m_valid));
    check_eq("fu_start", 32'(fu_start), 32'(m_start));
    if (m_valid) begin
      if (sb.size() == 0) check_eq("sb_nonempty", 32'd0, 32'd1);
      else begin
        check_eq("result_dst", 32'(result_dst), 32'(sb[0].dst));
        check_eq("result_src", 32'(result_src), 32'(sb[0].src));
      end
    end
    if (m_start && sb.size() > 0) begin
      check_eq("fu_func", 32'(fu_func), 32'(sb[$].func));
      check_eq("fu_inp1", 32'(fu_inp1), 32'(sb[$].i1));
      check_eq("fu_inp2", 32'(fu_inp2), 32'(sb[$].i2));
    end
    if (m_zero) begin
      check_eq("zero_fu", {fu_func, fu_inp1, fu_inp2}, 32'd0);
      check_eq("zero_res", {result_dst, result_src}, 32'd0);
    end

    if (reset) begin
      m_busy = 0; m_valid = 0; m_start = 0; m_rr = 0; m_rem = 0; m_zero = 1;
      sb.delete();
    end else if (flush) begin
      m_busy = 0; m_valid = 0; m_start = 0;
      sb.delete();
    end else begin
      m_start = 0;
      if (m_valid && ack) begin
        void'(sb.pop_front());
        m_busy  = 0;
        m_valid = 0;
      end else if (m_busy && !m_valid) begin
        m_rem--;
        if (m_rem == 0) m_valid = 1;
      end
      if (w >= 0) begin
        op.func = func[w*4 +: 4];
        op.i1   = inp1[w*5 +: 5];
        op.i2   = inp2[w*5 +: 5];
        op.dst  = dst[w*5 +: 5];
        op.src  = (w == 1);
        sb.push_back(op);
        m_rr    = (w + 1) % 2;
        m_busy  = 1;
        m_start = 1;
        m_rem   = LAT - 1;
        m_valid = (LAT == 1);
        m_zero  = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int       k;
    logic [4:0] d0;
    logic       s0;
    logic [4:0] q1[$];

    reset = 1; flush = 0; ack = 0; ready = 0;
    func = 0; inp1 = 0; inp2 = 0; dst = 0;
    flush1 = 0; ack1 = 0; ready1 = 0;
    func1 = 0; inp1_1 = 0; inp2_1 = 0; dst1 = 0;
    cyc(2);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_grant", 32'(grant), 32'd0);
    reset = 0;
    cyc(1);

    // Single op from queue 0, latency measured from the grant edge.
    set_ops();
    func[3:0] = ALU_ADD; inp1[4:0] = 5'd1; inp2[4:0] = 5'd2; dst[4:0] = 5'd3;
    ready = 2'b01;
    #1;
    check_eq("t1_grant", 32'(grant), 32'b01);
    cyc(1);
    ready = 2'b00;
    check_eq("t1_start", 32'(fu_start), 32'd1);
    check_eq("t1_inp1", 32'(fu_inp1), 32'd1);
    check_eq("t1_inp2", 32'(fu_inp2), 32'd2);
    k = 1;
    while (result_valid !== 1'b1 && k < 20) begin
      cyc(1);
      k++;
    end
    check_eq("t1_latency", 32'(k), 32'd3);
    check_eq("t1_dst", 32'(result_dst), 32'd3);
    check_eq("t1_src", 32'(result_src), 32'd0);
    ack = 1;
    cyc(1);
    ack = 0;
    cyc(1);

    // Both queues ready, ack tied high: alternating back-to-back grants.
    ready = 2'b11; ack = 1;
    for (int i = 0; i < 16; i++) begin
      set_ops();
      cyc(1);
    end

    // Hold the result in DONE with ack low for five cycles.
    ack = 0;
    wait_valid("t3_wait", 10);
    d0 = result_dst;
    s0 = result_src[0];
    for (int i = 0; i < 5; i++) begin
      set_ops();
      #1;
      check_eq("t3_hold_grant", 32'(grant), 32'd0);
      check_eq("t3_hold_valid", 32'(result_valid), 32'd1);
      check_eq("t3_hold_dst", 32'(result_dst), 32'(d0));
      cyc(1);
    end
    ack = 1;
    #1;
    check_eq("t3_ack_grant", 32'(grant), s0 ? 32'b01 : 32'b10);
    cyc(1);
    ready = 2'b00;
    cyc(6);

    // Flush in EXEC with one cycle left.
    ack = 0;
    set_ops();
    ready = 2'b10;
    #1;
    check_eq("t4_grant", 32'(grant), 32'b10);
    cyc(1);
    ready = 2'b11;
    cyc(1);
    flush = 1;
    #1;
    check_eq("t4_flush_grant", 32'(grant), 32'd0);
    cyc(1);
    flush = 0;
    #1;
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_valid", 32'(result_valid), 32'd0);
    check_eq("t4_next_grant", 32'(grant), 32'b01);
    cyc(1);
    ready = 2'b00;
    ack = 1;
    cyc(6);

    // Reset while holding a result in DONE.
    ack = 0;
    set_ops();
    ready = 2'b01;
    cyc(1);
    ready = 2'b00;
    wait_valid("t5_wait", 10);
    reset = 1;
    ready = 2'b11;
    #1;
    check_eq("t5_rst_grant", 32'(grant), 32'd0);
    cyc(1);
    check_eq("t5_valid", 32'(result_valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_start", 32'(fu_start), 32'd0);
    check_eq("t5_outs", {fu_func, fu_inp1, fu_inp2, result_dst, result_src}, 32'd0);
    check_eq("t5_grant_hi", 32'(grant), 32'd0);
    cyc(1);
    check_eq("t5_grant_hi2", 32'(grant), 32'd0);
    reset = 0;
    #1;
    check_eq("t5_first_grant", 32'(grant), 32'b01);
    cyc(1);
    ready = 2'b00;
    ack = 1;
    cyc(6);

    // Latency-1 instance: queue 1 streaming with ack tied high.
    ready1 = 2'b10;
    ack1 = 1;
    for (int i = 0; i < 8; i++) begin
      dst1[9:5] = 5'(i + 7);
      q1.push_back(5'(i + 7));
      #1;
      check_eq("l1_grant", 32'(grant1), 32'b10);
      if (i > 0) begin
        check_eq("l1_valid", 32'(result_valid1), 32'd1);
        check_eq("l1_start", 32'(fu_start1), 32'd1);
        check_eq("l1_dst", 32'(result_dst1), 32'(q1.pop_front()));
        check_eq("l1_src", 32'(result_src1), 32'd1);
      end
      cyc(1);
    end
    ready1 = 2'b00;
    cyc(3);
    check_eq("l1_idle", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fu_issue_arbiter.md
Name: fu_issue_arbiter

Overview:
- Shares one non-pipelined multi-cycle functional unit (MULT/DIV class) between NUM_REQ issue queues.
- Each cycle it picks one ready queue by round-robin and drives that queue's `issue` strobe. It latches the winning instruction's function code and register tags, then sequences the unit through its fixed latency.
- It holds the result tag until the common data bus accepts it.
- Sits between the issue queues' issue_ready/issue handshake and the FU/CDB interface.

Parameters:
- NUM_REQ, 2, number of issue queues sharing the unit (2..4).
- FUNC_WIDTH, 4, width of the function code (matches ALU1_FUNC encoding width).
- REG_ADDR_WIDTH, 5, physical register tag width.
- FU_LATENCY, 3, cycles from grant edge to result_valid (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of in-flight op.
- req_ready  in  NUM_REQ  issue_ready from each queue.
- req_func  in  NUM_REQ*FUNC_WIDTH  insn_out per queue; queue i occupies bits [i*FUNC_WIDTH +: FUNC_WIDTH].
- req_inp1  in  NUM_REQ*REG_ADDR_WIDTH  inp1_out per queue, packed the same way.
- req_inp2  in  NUM_REQ*REG_ADDR_WIDTH  inp2_out per queue.
- req_dst  in  NUM_REQ*REG_ADDR_WIDTH  dst_out per queue.
- grant  out  NUM_REQ  one-hot issue strobe to queues; combinational.
- fu_start  out  1  one-cycle pulse: operands valid at FU.
- fu_func  out  FUNC_WIDTH  latched function code.
- fu_inp1  out  REG_ADDR_WIDTH  latched source tag 1.
- fu_inp2  out  REG_ADDR_WIDTH  latched source tag 2.
- result_valid  out  1  result ready for CDB.
- result_dst  out  REG_ADDR_WIDTH  destination tag of result.
- result_src  out  $clog2(NUM_REQ) (min 1)  index of the queue that issued.
- cdb_ack  in  1  CDB accepted result this cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (sync, priority over all): state=IDLE, rr_ptr=0, cnt=0. All registered outputs are 0. grant=0 while reset is high.
- States: IDLE, EXEC, DONE.
- can_accept = (state==IDLE) | (state==DONE & cdb_ack). It is forced 0 when flush or reset is high.
- Arbitration (combinational):
  - If can_accept and any req_ready, grant the first i with req_ready[i]=1, scanning i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Otherwise grant=0.
  - grant is never asserted to a queue whose req_ready=0.
- On a clock edge with a grant to queue i:
  - Latch req_func/inp1/inp2/dst slice i.
  - Set result_src=i and rr_ptr=(i+1) mod NUM_REQ.
  - fu_start=1 for exactly the next cycle.
  - cnt=FU_LATENCY-1.
  - Next state is EXEC, or DONE directly if FU_LATENCY==1.
- EXEC: cnt decrements each cycle. When cnt==1 at an edge, next state is DONE.
  - Net effect: result_valid rises exactly FU_LATENCY cycles after the grant edge.
- DONE: result_valid=1 and result_dst is stable until cdb_ack.
  - cdb_ack with no grant -> IDLE.
  - cdb_ack with a grant -> new op is latched and state goes to EXEC/DONE. This is back-to-back operation with no bubble; result_valid drops for at least one cycle unless FU_LATENCY==1.
- cdb_ack outside DONE is ignored.
- flush: next state IDLE, result_valid=0, fu_start=0, no grant that cycle. rr_ptr is unchanged.
- result_dst/result_src/fu_* hold their last values when idle. They are don't-care unless qualified.
- No grant is issued in EXEC, or in DONE without cdb_ack (FU is non-pipelined).
- Width rule: rr_ptr wraps modulo NUM_REQ for non-power-of-two NUM_REQ.

Test Plan:
- Reset, then req_ready=2'b01, queue0 func=ALU_ADD, inp1=1, inp2=2, dst=3, FU_LATENCY=3.
  - grant=01 for one cycle, then fu_start pulse with fu_inp1=1, fu_inp2=2.
  - result_valid high 3 cycles after the grant edge, result_dst=3, result_src=0.
- Both queues ready continuously, cdb_ack tied high.
  - Grants alternate 01,10,01,10.
  - Back-to-back: grant occurs in the same cycle as ack, with no IDLE cycle between ops.
- Hold cdb_ack=0 for 5 cycles in DONE with both queues ready.
  - result_valid and result_dst stay stable.
  - grant=00 throughout.
  - On ack, grant goes to the queue after the last winner.
- Assert flush in EXEC (cnt=1).
  - Next cycle: busy=0, result_valid=0, no result for that op.
  - rr_ptr is unchanged: the next grant goes to the queue after the flushed op's issuer.
- Assert reset while in DONE with result_valid=1.
  - Next cycle: all outputs 0, grant=00 while reset is high.
  - First grant after release goes to queue 0.
- FU_LATENCY=1 build, queue1 only ready, ack tied high.
  - result_valid in the cycle after each grant.
  - grant=10 every cycle and result_valid continuously high.
